// File: rtl/serial_word_tx.sv
// serial_word_tx: single-entry word buffer feeding a framed MSB-first serial shifter
// with sof/eof markers and a configurable idle gap between frames.
module serial_word_tx #(
  parameter int DATA_W     = 32,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              op,
  output logic              op_valid,
  output logic              sof,
  output logic              eof,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST  = CW'(DATA_W - 1);
  localparam logic [GW-1:0] GINIT = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_buf, r_sr;
  logic              r_buf_full;
  logic [CW-1:0]     r_bcnt;
  logic [GW-1:0]     r_gcnt;
  logic              w_last, w_gap_done, w_load, w_accept;

  assign w_last     = r_bcnt == '0;
  assign w_gap_done = r_gcnt == '0;
  assign w_accept   = din_valid && !r_buf_full;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  // w_load marks every edge where the buffered word moves into the shifter
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      IDLE: begin
        w_load = r_buf_full;
        w_next = r_buf_full ? SHIFT : IDLE;
      end
      SHIFT:
        if (w_last) begin
          if (GAP_CYCLES > 0) w_next = GAP;
          else begin
            w_load = r_buf_full;
            w_next = r_buf_full ? SHIFT : IDLE;
          end
        end
      GAP:
        if (w_gap_done) begin
          w_load = r_buf_full;
          w_next = r_buf_full ? SHIFT : IDLE;
        end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_sr       <= '0;
      r_bcnt     <= '0;
      r_gcnt     <= '0;
    end else begin
      if (w_accept) begin
        r_buf      <= din;
        r_buf_full <= 1'b1;
      end else if (w_load) r_buf_full <= 1'b0;
      if (w_load) begin
        r_sr   <= r_buf;
        r_bcnt <= LAST;
      end else if (r_state == SHIFT && !w_last) begin
        r_sr   <= {r_sr[DATA_W-2:0], 1'b0};
        r_bcnt <= r_bcnt - CW'(1);
      end
      if (r_state == SHIFT && w_last) r_gcnt <= GINIT;
      else if (r_state == GAP && !w_gap_done) r_gcnt <= r_gcnt - GW'(1);
    end

  always_comb begin
    op_valid  = r_state == SHIFT;
    op        = op_valid ? r_sr[DATA_W-1] : 1'b0;
    sof       = op_valid ? r_bcnt == LAST : 1'b0;
    eof       = op_valid ? w_last : 1'b0;
    busy      = r_state != IDLE || r_buf_full;
    din_ready = !r_buf_full;
  end
endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: three instances (gap 1, 0, 3) checked cycle by cycle against a
// frame-timing model built from acceptance/load times rather than FSM states.
module tb_serial_word_tx;
  localparam int W = 32;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din[3];
  logic         dv[3], rdy[3], op[3], ov[3], sof[3], eof[3], busy[3];
  logic [5:0]   tr[512];
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  serial_word_tx #(.DATA_W(W), .GAP_CYCLES(1)) u_g1 (
    .clk(clk), .rst_n(rst_n), .din(din[0]), .din_valid(dv[0]), .din_ready(rdy[0]),
    .op(op[0]), .op_valid(ov[0]), .sof(sof[0]), .eof(eof[0]), .busy(busy[0]));
  serial_word_tx #(.DATA_W(W), .GAP_CYCLES(0)) u_g0 (
    .clk(clk), .rst_n(rst_n), .din(din[1]), .din_valid(dv[1]), .din_ready(rdy[1]),
    .op(op[1]), .op_valid(ov[1]), .sof(sof[1]), .eof(eof[1]), .busy(busy[1]));
  serial_word_tx #(.DATA_W(W), .GAP_CYCLES(3)) u_g3 (
    .clk(clk), .rst_n(rst_n), .din(din[2]), .din_valid(dv[2]), .din_ready(rdy[2]),
    .op(op[2]), .op_valid(ov[2]), .sof(sof[2]), .eof(eof[2]), .busy(busy[2]));

  function automatic int gap_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 3;
  endfunction

  function automatic logic [5:0] pack(input int k);
    return {rdy[k], busy[k], eof[k], sof[k], ov[k], op[k]};
  endfunction

  // Word i is accepted at edge a, loaded at edge l = max(a+1, previous load + W + gap),
  // and its bits appear in samples l..l+W-1; with din_valid held, the next word is
  // accepted one edge after the buffer frees. Result: {ready,busy,eof,sof,valid,bit}.
  function automatic logic [5:0] model_at(input int j, input int g, input logic [W-1:0] w[$]);
    int a, l, pl;
    logic bf, sh, gp, o, s, e;
    a = 0; pl = -1000; bf = 0; sh = 0; gp = 0; o = 0; s = 0; e = 0;
    foreach (w[i]) begin
      l = (a + 1 > pl + W + g) ? a + 1 : pl + W + g;
      if (j >= a && j < l) bf = 1;
      if (j >= l && j < l + W) begin
        sh = 1; o = w[i][W-1-(j-l)]; s = (j == l); e = (j == l + W - 1);
      end
      if (j >= l + W && j < l + W + g) gp = 1;
      pl = l; a = l + 1;
    end
    return {!bf, bf | sh | gp, e, s, sh, o};
  endfunction

  // Holds din_valid and presents the words in order, advancing on each handshake;
  // sample j is taken on the falling edge after rising edge j.
  task automatic run(input int k, input logic [W-1:0] w[$], input int n);
    int idx;
    logic rp, acc;
    @(posedge clk); #1;
    din[k] = w[0]; dv[k] = 1'b1; idx = 0; rp = rdy[k];
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      acc = dv[k] && rp;
      #1;
      if (acc) begin
        idx++;
        if (idx < w.size()) din[k] = w[idx];
        else dv[k] = 1'b0;
      end
      @(negedge clk);
      tr[j] = pack(k);
      rp = rdy[k];
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ov[k], sof[k], eof[k], busy[k], rdy[k]} !== 5'b00001) begin
        errors++;
        $display("FAIL reset_hold k=%0d got=%b exp=00001", k, {ov[k], sof[k], eof[k], busy[k], rdy[k]});
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({ov[k], busy[k], rdy[k]} !== 3'b001) begin
          errors++;
          $display("FAIL reset_idle k=%0d c=%0d got=%b exp=001", k, c, {ov[k], busy[k], rdy[k]});
        end
      end
    end
  endtask

  task automatic test_single;
    logic [W-1:0] w[$];
    logic [5:0] e;
    int nv;
    w = '{32'hA5A5_0001};
    run(0, w, W + 12);
    nv = 0;
    for (int j = 0; j < W + 12; j++) begin
      e = model_at(j, 1, w);
      nv += int'(tr[j][1]);
      checks++;
      if ((tr[j] & {5'h1f, e[1]}) !== e) begin
        errors++;
        $display("FAIL single j=%0d got=%b exp=%b", j, tr[j], e);
      end
    end
    checks++;
    if (nv !== W) begin
      errors++;
      $display("FAIL single_len got=%0d exp=%0d", nv, W);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] w[$];
    logic [5:0] e;
    w = '{32'hFFFF_FFFF, 32'h0000_0000};
    run(1, w, 2 * W + 8);
    for (int j = 0; j < 2 * W + 8; j++) begin
      e = model_at(j, 0, w);
      checks++;
      if ((tr[j] & {5'h1f, e[1]}) !== e) begin
        errors++;
        $display("FAIL back_to_back j=%0d got=%b exp=%b", j, tr[j], e);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] w[$];
    logic [5:0] e;
    w = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
    run(0, w, 3 * (W + 1) + 8);
    for (int j = 0; j < 3 * (W + 1) + 8; j++) begin
      e = model_at(j, 1, w);
      checks++;
      if ((tr[j] & {5'h1f, e[1]}) !== e) begin
        errors++;
        $display("FAIL backpressure j=%0d got=%b exp=%b", j, tr[j], e);
      end
    end
  endtask

  task automatic test_gap;
    logic [W-1:0] w[$];
    logic [5:0] e;
    w = '{32'hDEAD_BEEF, 32'h0F0F_F0F0};
    run(2, w, 2 * (W + 3) + 8);
    for (int j = 0; j < 2 * (W + 3) + 8; j++) begin
      e = model_at(j, 3, w);
      checks++;
      if ((tr[j] & {5'h1f, e[1]}) !== e) begin
        errors++;
        $display("FAIL gap j=%0d got=%b exp=%b", j, tr[j], e);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] w[$];
    logic [5:0] e;
    int n, g;
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < 2; r++) begin
        w = {};
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) w.push_back($urandom);
        g = gap_of(k);
        run(k, w, n * (W + g) + 8);
        for (int j = 0; j < n * (W + g) + 8; j++) begin
          e = model_at(j, g, w);
          checks++;
          if ((tr[j] & {5'h1f, e[1]}) !== e) begin
            errors++;
            $display("FAIL random k=%0d r=%0d j=%0d got=%b exp=%b", k, r, j, tr[j], e);
          end
        end
      end
  endtask

  task automatic test_mid_reset;
    logic [W-1:0] a, b;
    a = 32'h1234_5678;
    b = 32'hCAFE_0042;
    @(posedge clk); #1;
    din[0] = a; dv[0] = 1'b1;
    @(posedge clk); #1;
    din[0] = b;
    @(posedge clk);
    @(posedge clk); #1;
    dv[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_buffered got=%b exp=0", rdy[0]);
    end
    repeat (9) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ov[0], op[0]} !== {1'b1, a[W-1-10]}) begin
      errors++;
      $display("FAIL mid_reset_bit10 got=%b exp=%b", {ov[0], op[0]}, {1'b1, a[W-1-10]});
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({ov[0], sof[0], eof[0], op[0], busy[0], rdy[0]} !== 6'b000001) begin
      errors++;
      $display("FAIL mid_reset_async got=%b exp=000001", {ov[0], sof[0], eof[0], op[0], busy[0], rdy[0]});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if ({ov[0], busy[0]} !== 2'b00) begin
        errors++;
        $display("FAIL mid_reset_quiet c=%0d got=%b exp=00", c, {ov[0], busy[0]});
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      din[k] = '0;
      dv[k] = 1'b0;
    end
    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_gap;
    test_random;
    test_mid_reset;
    test_single;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
